// File: rtl/spi_fifo_pkg.sv
// -----------------------------------------------------------------------------
// spi_fifo_pkg
//
// Shared definitions for the SPI transmit FIFO slice.
//   ptr_w(depth)  : address / pointer width for a FIFO of the given depth
//   cnt_w(depth)  : occupancy counter width; one extra bit so that a completely
//                   full FIFO (count == depth) is representable
//   fifo_err_t    : sticky error flags (overflow, underflow) used when the
//                   optional error reporting is built in
// -----------------------------------------------------------------------------
package spi_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;

endpackage : spi_fifo_pkg

// File: rtl/spi_fifo_ram.sv
// -----------------------------------------------------------------------------
// spi_fifo_ram
//
// Simple dual-port storage array: one synchronous write port and one read port
// with a registered output. The output register is the only resettable state;
// the array itself has no reset and is never read before it is written.
//
// Parameters:
//   width_g  word width
//   depth_g  number of entries (power of 2)
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset (output register only)
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write word
//   rd_en    read enable; loads rd_data from rd_addr on the next edge
//   rd_addr  read address
//   rd_data  registered read word; holds its value while rd_en is low
// -----------------------------------------------------------------------------
module spi_fifo_ram
  import spi_fifo_pkg::*;
#(
  parameter int width_g = 8,
  parameter int depth_g = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ptr_w(depth_g)-1:0]   wr_addr,
  input  logic [width_g-1:0]          wr_data,
  input  logic                        rd_en,
  input  logic [ptr_w(depth_g)-1:0]   rd_addr,
  output logic [width_g-1:0]          rd_data
);

  logic [width_g-1:0] mem [depth_g];

  // Array write port. No reset so this maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port. The register holds its last word when no read is
  // requested, which is what keeps the downstream data stable across a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : spi_fifo_ram

// File: rtl/spi_tx_fifo.sv
// -----------------------------------------------------------------------------
// spi_tx_fifo
//
// Transmit-side buffer feeding the FIFO request port of spi_master. A host
// writer pushes words with wr_en; spi_master pulls one word per request and
// sees it one cycle later qualified by a single-cycle fifo_din_valid pulse.
//
// Build option:
//   SPI_TX_FIFO_ERR_EN  when defined, adds sticky ovf_err / udf_err outputs.
//                       When undefined, dropped writes and ignored requests
//                       are silent and those ports do not exist.
//
// Parameters:
//   data_width_g    word width (matches spi_master)
//   depth_g         number of entries, power of 2, >= 2
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   flush           synchronous clear of all contents (wins over wr/req)
//   wr_en, wr_data  write strobe and word
//   full            count == depth_g
//   used            number of stored words
//   fifo_req_data   read request from spi_master
//   fifo_din        registered read word
//   fifo_din_valid  one-cycle pulse qualifying fifo_din
//   fifo_empty      count == 0
//   ovf_err         (option) sticky: write attempted while full
//   udf_err         (option) sticky: request made while empty
// -----------------------------------------------------------------------------
module spi_tx_fifo
  import spi_fifo_pkg::*;
#(
  parameter int data_width_g = 8,
  parameter int depth_g      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [data_width_g-1:0]     wr_data,
  output logic                        full,
  output logic [cnt_w(depth_g)-1:0]   used,
  input  logic                        fifo_req_data,
  output logic [data_width_g-1:0]     fifo_din,
  output logic                        fifo_din_valid,
  output logic                        fifo_empty
`ifdef SPI_TX_FIFO_ERR_EN
  ,
  output logic                        ovf_err,
  output logic                        udf_err
`endif
);

  localparam int ptr_width = ptr_w(depth_g);
  localparam int cnt_width = cnt_w(depth_g);

  localparam logic [ptr_width-1:0] ptr_one  = ptr_width'(1);
  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);
  localparam logic [cnt_width-1:0] cnt_full = cnt_width'(depth_g);

  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic [cnt_width-1:0] count;
  logic [cnt_width-1:0] count_next;
  logic                 din_valid;

  logic wr_accept;
  logic rd_accept;
  logic ram_we;
  logic ram_re;

  // Flags come only from the registered count, so full / fifo_empty never
  // have a combinational path from wr_en or fifo_req_data.
  assign full           = (count == cnt_full);
  assign fifo_empty     = (count == '0);
  assign used           = count;
  assign fifo_din_valid = din_valid;

  // Acceptance and array strobes. A request while empty is simply refused,
  // even if a write lands in the same cycle: there is no fall-through path.
  // Flush suppresses both array accesses so fifo_din keeps its last word.
  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = fifo_req_data && !fifo_empty;
    ram_we    = wr_accept && !flush;
    ram_re    = rd_accept && !flush;
  end

  // Occupancy update: a simultaneous accepted read and write leaves the count
  // unchanged. Because a read needs count >= 1 and a write needs count < depth,
  // the two pointers can never address the same entry in the same cycle.
  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + cnt_one;
      2'b01:   count_next = count - cnt_one;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      din_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      din_valid <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      count     <= count_next;
      din_valid <= rd_accept;
    end
  end

  spi_fifo_ram #(
    .width_g (data_width_g),
    .depth_g (depth_g)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr),
    .rd_data (fifo_din)
  );

`ifdef SPI_TX_FIFO_ERR_EN
  fifo_err_t err_q;

  // Sticky error flags; only flush or reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (flush) begin
      err_q <= '0;
    end else begin
      err_q.ovf <= err_q.ovf | (wr_en & full);
      err_q.udf <= err_q.udf | (fifo_req_data & fifo_empty);
    end
  end

  assign ovf_err = err_q.ovf;
  assign udf_err = err_q.udf;
`endif

endmodule : spi_tx_fifo

// File: tb/tb_spi_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_fifo
//
// Directed self-checking bench for spi_tx_fifo (depth 16, width 8). Inputs
// are driven 1 ns after each rising edge and outputs are checked at that same
// point, so each check sees the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_spi_tx_fifo;

  localparam int data_width = 8;
  localparam int depth      = 16;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [4:0] used;
  logic       fifo_req_data;
  logic [7:0] fifo_din;
  logic       fifo_din_valid;
  logic       fifo_empty;
`ifdef SPI_TX_FIFO_ERR_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  int assertCount = 0;
  int failCount   = 0;

  spi_tx_fifo #(
    .data_width_g (data_width),
    .depth_g      (depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .used           (used),
    .fifo_req_data  (fifo_req_data),
    .fifo_din       (fifo_din),
    .fifo_din_valid (fifo_din_valid),
    .fifo_empty     (fifo_empty)
`ifdef SPI_TX_FIFO_ERR_EN
    ,
    .ovf_err        (ovf_err),
    .udf_err        (udf_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, take the rising edge, settle 1 ns.
  task automatic applyStimulus(input logic we, input logic [7:0] wd,
                               input logic req, input logic fl);
    wr_en         = we;
    wr_data       = wd;
    fifo_req_data = req;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " used"},  32'(used), 32'd0);
    checkOutput({tag, " empty"}, 32'(fifo_empty), 32'd1);
    checkOutput({tag, " full"},  32'(full), 32'd0);
    checkOutput({tag, " valid"}, 32'(fifo_din_valid), 32'd0);
    checkOutput({tag, " din"},   32'(fifo_din), 32'd0);
`ifdef SPI_TX_FIFO_ERR_EN
    checkOutput({tag, " ovf"},   32'(ovf_err), 32'd0);
    checkOutput({tag, " udf"},   32'(udf_err), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] expWord;

    rst           = 1'b0;
    flush         = 1'b0;
    wr_en         = 1'b0;
    wr_data       = 8'h00;
    fifo_req_data = 1'b0;

    // Reset state
    #12;
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Three writes, then three back-to-back requests
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("wr1 empty", 32'(fifo_empty), 32'd0);
    checkOutput("wr1 used",  32'(used), 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("wr3 used",  32'(used), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rd1 valid", 32'(fifo_din_valid), 32'd1);
    checkOutput("rd1 din",   32'(fifo_din), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rd2 valid", 32'(fifo_din_valid), 32'd1);
    checkOutput("rd2 din",   32'(fifo_din), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rd3 valid", 32'(fifo_din_valid), 32'd1);
    checkOutput("rd3 din",   32'(fifo_din), 32'h33);
    checkOutput("rd3 empty", 32'(fifo_empty), 32'd1);
    checkOutput("rd3 used",  32'(used), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle valid", 32'(fifo_din_valid), 32'd0);
    checkOutput("idle din hold", 32'(fifo_din), 32'h33);

    // Request on empty FIFO is ignored
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf valid", 32'(fifo_din_valid), 32'd0);
    checkOutput("udf used",  32'(used), 32'd0);
`ifdef SPI_TX_FIFO_ERR_EN
    checkOutput("udf flag",  32'(udf_err), 32'd1);
`endif

    // Write while empty with a simultaneous request: no fall-through
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    checkOutput("nofall valid", 32'(fifo_din_valid), 32'd0);
    checkOutput("nofall used",  32'(used), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("nofall rd din", 32'(fifo_din), 32'h5A);
    checkOutput("nofall rd valid", 32'(fifo_din_valid), 32'd1);

    // Fill to 16, 17th write dropped, read back 0x00..0x0F
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 14) checkOutput("fill15 full", 32'(full), 32'd0);
      if (i == 15) checkOutput("fill16 full", 32'(full), 32'd1);
    end
    checkOutput("ovf used", 32'(used), 32'd16);
    checkOutput("ovf full", 32'(full), 32'd1);
`ifdef SPI_TX_FIFO_ERR_EN
    checkOutput("ovf flag", 32'(ovf_err), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("drain%0d din", i), 32'(fifo_din), 32'(i));
      checkOutput($sformatf("drain%0d valid", i), 32'(fifo_din_valid), 32'd1);
      if (i == 0) checkOutput("drain0 full", 32'(full), 32'd0);
    end
    checkOutput("drain used",  32'(used), 32'd0);
    checkOutput("drain empty", 32'(fifo_empty), 32'd1);

    // Simultaneous read and write at used == 1 for 40 cycles
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 8'(8'hA1 + k), 1'b1, 1'b0);
      expWord = 8'(8'hA0 + k);
      checkOutput($sformatf("rw%0d used", k), 32'(used), 32'd1);
      checkOutput($sformatf("rw%0d din", k), 32'(fifo_din), 32'(expWord));
      checkOutput($sformatf("rw%0d valid", k), 32'(fifo_din_valid), 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rw last din", 32'(fifo_din), 32'hC8);
    checkOutput("rw last used", 32'(used), 32'd0);

    // Fill 5, flush with wr_en high
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
    end
    checkOutput("pre-flush used", 32'(used), 32'd5);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    checkOutput("flush used",  32'(used), 32'd0);
    checkOutput("flush empty", 32'(fifo_empty), 32'd1);
    checkOutput("flush valid", 32'(fifo_din_valid), 32'd0);
    checkOutput("flush din hold", 32'(fifo_din), 32'hC8);
`ifdef SPI_TX_FIFO_ERR_EN
    checkOutput("flush ovf", 32'(ovf_err), 32'd0);
    checkOutput("flush udf", 32'(udf_err), 32'd0);
`endif
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post-flush din", 32'(fifo_din), 32'h77);
    checkOutput("post-flush used", 32'(used), 32'd0);

    // Flush wins over a request and kills a pending valid
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("flushreq valid", 32'(fifo_din_valid), 32'd0);
    checkOutput("flushreq din",   32'(fifo_din), 32'h77);
    checkOutput("flushreq used",  32'(used), 32'd0);

    // Asynchronous reset mid-burst while fifo_din_valid is high
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("burst valid", 32'(fifo_din_valid), 32'd1);
    checkOutput("burst din",   32'(fifo_din), 32'hC1);
    #2;
    rst           = 1'b0;
    fifo_req_data = 1'b0;
    #1;
    checkResetValues("async rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post-rst valid", 32'(fifo_din_valid), 32'd0);
    checkOutput("post-rst used",  32'(used), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule : tb_spi_tx_fifo
